// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit behind a valid/ready handshake.
// Optional build macro MULDIV_REM_EN adds select 4'b0100 = unsigned remainder on the divide datapath.
module alu_muldiv_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   select,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    output logic         div_zero
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;

    localparam logic [3:0] SEL_MUL = 4'b0010;
    localparam logic [3:0] SEL_DIV = 4'b0011;
    localparam logic [3:0] SEL_REM = 4'b0100;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [1:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_acc;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_res;
    logic          r_dz;
    logic          r_in_ready;
    logic          r_out_valid;

    logic [N:0]    w_rem_shift;
    logic          w_ge;
    logic [N:0]    w_rem_nxt;
    logic [N-1:0]  w_quo_nxt;
    logic [N-1:0]  w_acc_nxt;
    logic [N-1:0]  w_fin;
    logic          w_is_mul;
    logic          w_is_div;
    logic          w_is_rem;
    logic          w_b_zero;
    logic          w_go_busy;
    logic [1:0]    w_op;
    logic [N-1:0]  w_fast_res;
    logic          w_fast_dz;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign div_zero  = r_dz;

    // One iteration of each datapath: shift-add multiply step and restoring divide step.
    always_comb begin
        w_rem_shift = {r_rem[N-1:0], r_a[N-1]};
        // r_rem[N] is always clear between steps; folding it in keeps the compare full-width.
        w_ge        = r_rem[N] | (w_rem_shift >= {1'b0, r_b});
        if (w_ge) begin
            w_rem_nxt = w_rem_shift - {1'b0, r_b};
        end else begin
            w_rem_nxt = w_rem_shift;
        end
        w_quo_nxt = {r_a[N-2:0], w_ge};
        if (r_b[0]) begin
            w_acc_nxt = r_acc + r_a;
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    // Result captured on the final BUSY iteration.
    always_comb begin
        w_fin = {N{1'b0}};
        case (r_op)
            OP_MUL:  w_fin = w_acc_nxt;
            OP_DIV:  w_fin = w_quo_nxt;
`ifdef MULDIV_REM_EN
            OP_REM:  w_fin = w_rem_nxt[N-1:0];
`endif
            default: w_fin = {N{1'b0}};
        endcase
    end

    // Request decode: choose between the iterative path and single-edge completion.
    always_comb begin
        w_is_mul = (select == SEL_MUL);
        w_is_div = (select == SEL_DIV);
`ifdef MULDIV_REM_EN
        w_is_rem = (select == SEL_REM);
`else
        w_is_rem = 1'b0;
`endif
        w_b_zero  = (B == {N{1'b0}});
        w_go_busy = w_is_mul | ((w_is_div | w_is_rem) & ~w_b_zero);
        if (w_is_mul) begin
            w_op = OP_MUL;
        end else if (w_is_rem) begin
            w_op = OP_REM;
        end else begin
            w_op = OP_DIV;
        end
        w_fast_dz  = (w_is_div | w_is_rem) & w_b_zero;
        if (w_is_div & w_b_zero) begin
            w_fast_res = {N{1'b1}};
        end else if (w_is_rem & w_b_zero) begin
            w_fast_res = A;
        end else begin
            w_fast_res = {N{1'b0}};
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_MUL;
            r_cnt       <= {CW{1'b0}};
            r_a         <= {N{1'b0}};
            r_b         <= {N{1'b0}};
            r_acc       <= {N{1'b0}};
            r_rem       <= {(N+1){1'b0}};
            r_res       <= {N{1'b0}};
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= A;
                        r_b        <= B;
                        r_cnt      <= {CW{1'b0}};
                        r_acc      <= {N{1'b0}};
                        r_rem      <= {(N+1){1'b0}};
                        r_op       <= w_op;
                        r_in_ready <= 1'b0;
                        if (w_go_busy) begin
                            r_state <= S_BUSY;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_res       <= w_fast_res;
                            r_dz        <= w_fast_dz;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_op == OP_MUL) begin
                        r_acc <= w_acc_nxt;
                        r_a   <= {r_a[N-2:0], 1'b0};
                        r_b   <= {1'b0, r_b[N-1:1]};
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_a   <= w_quo_nxt;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_res       <= w_fin;
                        r_dz        <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq (N=32); expectations follow MULDIV_REM_EN when defined.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  select;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        div_zero;

    int n_vec;
    int n_err;

    alu_muldiv_seq #(.N(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called #1 after the accept edge; counts edges with the accept edge as 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel, input logic [31:0] exp_res,
                          input logic exp_dz, input int exp_lat);
        int lat;
        @(negedge clk);
        A = a; B = b; select = sel; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h0000_0000; select = 4'b0000;
        wait_done(lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, res, exp_res);
        check_eq({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
        @(posedge clk);
        #1;
        check_eq({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = 32'd0; B = 32'd0; select = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_res", res, 32'd0);
        check_eq("rst_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul7x6", 32'd7, 32'd6, 4'b0010, 32'd42, 1'b0, 33);
        run_op("mul_trunc", 32'hFFFF_FFFF, 32'd2, 4'b0010, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("div100_7", 32'd100, 32'd7, 4'b0011, 32'd14, 1'b0, 33);
        run_op("div_by0", 32'd5, 32'd0, 4'b0011, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("unsup", 32'd5, 32'd9, 4'b0110, 32'd0, 1'b0, 1);
        run_op("div_big", 32'hFFFF_FFFF, 32'h0001_0000, 4'b0011, 32'h0000_FFFF, 1'b0, 33);
`ifdef MULDIV_REM_EN
        run_op("rem100_7", 32'd100, 32'd7, 4'b0100, 32'd2, 1'b0, 33);
        run_op("rem_by0", 32'd9, 32'd0, 4'b0100, 32'd9, 1'b1, 1);
`else
        run_op("rem100_7", 32'd100, 32'd7, 4'b0100, 32'd0, 1'b0, 1);
        run_op("rem_by0", 32'd9, 32'd0, 4'b0100, 32'd0, 1'b0, 1);
`endif

        // Backpressure: result held, and a pending request waits for the handshake.
        @(negedge clk);
        out_ready = 1'b0; A = 32'd3; B = 32'd4; select = 4'b0010; in_valid = 1'b1;
        @(posedge clk);
        #1;
        A = 32'd2; B = 32'd5;
        wait_done(lat);
        check_eq("bp_lat", 32'(lat), 32'd33);
        check_eq("bp_res", res, 32'd12);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_res", res, 32'd12);
            check_eq("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            check_eq("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_hs_vld", {31'd0, out_valid}, 32'd0);
        check_eq("bp_hs_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp_acc2_rdy", {31'd0, in_ready}, 32'd0);
        wait_done(lat);
        check_eq("bp2_lat", 32'(lat), 32'd33);
        check_eq("bp2_res", res, 32'd10);
        @(posedge clk);
        #1;

        // Reset in the middle of a divide.
        @(negedge clk);
        A = 32'd1000; B = 32'd3; select = 4'b0011; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        check_eq("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_res", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            check_eq("mid_rst_no_emit", {31'd0, out_valid}, 32'd0);
        end
        run_op("div9_3", 32'd9, 32'd3, 4'b0011, 32'd3, 1'b0, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
